// File: rtl/dlfloat_dot_ctrl_if.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_ctrl_if
//   Bundles the signals between the dot-product sequencer and its neighbours:
//   the host-side operand unpacker (job request, operand stream, result) and
//   the shared DLFloat16 multiply-accumulate datapath.
//
//   Job request : start, cfg_len, start_ready, abort
//   Operands    : in_valid, in_a, in_b, in_ready
//   MAC side    : mac_a, mac_b, mac_clr, mac_acc
//   Result      : res_data, res_nan, res_valid, res_ready
//   Status      : busy
//
//   slave  - the sequencer itself
//   master - the surrounding environment (host unpacker plus MAC)
// ---------------------------------------------------------------------------
interface dlfloat_dot_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] cfg_len;
    logic             start_ready;
    logic             abort;

    logic             in_valid;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             in_ready;

    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_clr;
    logic [15:0]      mac_acc;

    logic [15:0]      res_data;
    logic             res_nan;
    logic             res_valid;
    logic             res_ready;

    logic             busy;

    modport slave (
        input  start, cfg_len, abort, in_valid, in_a, in_b, mac_acc, res_ready,
        output start_ready, in_ready, mac_a, mac_b, mac_clr,
               res_data, res_nan, res_valid, busy
    );

    modport master (
        output start, cfg_len, abort, in_valid, in_a, in_b, mac_acc, res_ready,
        input  start_ready, in_ready, mac_a, mac_b, mac_clr,
               res_data, res_nan, res_valid, busy
    );
endinterface

// File: rtl/dlfloat_dot_ctrl.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_ctrl
//   Sequencer for length-N DLFloat16 dot products on the shared MAC.
//   A job clears the accumulator, streams cfg_len operand pairs into the MAC,
//   waits MAC_LAT+1 cycles for the last product to land in the accumulator,
//   then holds the captured sum on res_data/res_valid until res_ready.
//
//   Ports
//     clk    - clock
//     rst_n  - synchronous active-low reset
//     bus    - dlfloat_dot_ctrl_if.slave (job, operand stream, MAC, result)
//
//   Parameters
//     MAC_LAT - edges from an operand pair on mac_a/mac_b to the accumulator
//               holding its contribution
//     CNT_W   - width of job-length and pair counters
// ---------------------------------------------------------------------------
module dlfloat_dot_ctrl #(
    parameter int MAC_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlfloat_dot_ctrl_if.slave    bus
);
    localparam int          DCNT_W  = $clog2(MAC_LAT + 1);
    localparam logic [15:0] DL_NAN  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  pair_cnt_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic              nan_q;

    logic [15:0]       mac_a_q;
    logic [15:0]       mac_b_q;
    logic              mac_clr_q;
    logic [15:0]       res_data_q;
    logic              res_nan_q;
    logic              res_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pair_cnt_q  <= '0;
            dcnt_q      <= '0;
            nan_q       <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_clr_q   <= 1'b0;
            res_data_q  <= '0;
            res_nan_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            // Operands default to zero so any cycle without an issued pair
            // is a bubble that adds nothing to the accumulator.
            mac_a_q   <= '0;
            mac_b_q   <= '0;
            mac_clr_q <= 1'b0;

            if (bus.abort && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                res_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            len_q      <= bus.cfg_len;
                            pair_cnt_q <= '0;
                            nan_q      <= 1'b0;
                            // Registered clear is high for the whole CLR cycle.
                            mac_clr_q  <= 1'b1;
                            state_q    <= S_CLR;
                        end
                    end

                    S_CLR: begin
                        if (len_q != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            dcnt_q  <= DCNT_W'(MAC_LAT);
                            state_q <= S_DRAIN;
                        end
                    end

                    S_RUN: begin
                        if (bus.in_valid) begin
                            mac_a_q    <= bus.in_a;
                            mac_b_q    <= bus.in_b;
                            pair_cnt_q <= pair_cnt_q + CNT_W'(1);
                            if (bus.in_a == DL_NAN || bus.in_b == DL_NAN) begin
                                nan_q <= 1'b1;
                            end
                            if (pair_cnt_q == len_q - CNT_W'(1)) begin
                                dcnt_q  <= DCNT_W'(MAC_LAT);
                                state_q <= S_DRAIN;
                            end
                        end
                    end

                    S_DRAIN: begin
                        // dcnt reaching zero means the last product has been
                        // folded into mac_acc on the previous edge.
                        if (dcnt_q != '0) begin
                            dcnt_q <= dcnt_q - DCNT_W'(1);
                        end else begin
                            res_data_q  <= bus.mac_acc;
                            res_nan_q   <= nan_q | (bus.mac_acc == DL_NAN);
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        if (bus.res_ready) begin
                            res_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.in_ready    = (state_q == S_RUN);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.mac_a       = mac_a_q;
    assign bus.mac_b       = mac_b_q;
    assign bus.mac_clr     = mac_clr_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_nan     = res_nan_q;
    assign bus.res_valid   = res_valid_q;

endmodule

// File: tb/tb_dlfloat_dot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dlfloat_dot_ctrl
//   Bench for dlfloat_dot_ctrl. Plays the host unpacker and a behavioural
//   two-stage DLFloat16 MAC (product register, then accumulator register,
//   sticky NaN). Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dlfloat_dot_ctrl;
    localparam int MAC_LAT = 2;
    localparam int CNT_W   = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    dlfloat_dot_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dlfloat_dot_ctrl #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DLFloat16 helpers and MAC model
    // ------------------------------------------------------------------
    function automatic real from_dl(logic [15:0] x);
        real m;
        int  e;
        if (x[14:9] == 6'd0) return 0.0;
        m = 1.0 + real'(x[8:0]) / 512.0;
        e = int'(x[14:9]) - 31;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] to_dl(real v);
        logic       s;
        real        m;
        int         e;
        int         mi;
        logic [5:0] ev;
        logic [8:0] mv;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 31;
        while (m >= 2.0 && e < 63) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1)   begin m = m * 2.0; e--; end
        mi = int'((m - 1.0) * 512.0);
        if (mi > 511) mi = 511;
        if (mi < 0)   mi = 0;
        ev = 6'(e);
        mv = 9'(mi);
        return {s, ev, mv};
    endfunction

    real         prod_q;
    real         acc_q;
    logic        pnan_q;
    logic        anan_q;
    logic [15:0] acc_dl;

    initial begin
        prod_q = 0.0;
        acc_q  = 0.0;
        pnan_q = 1'b0;
        anan_q = 1'b0;
    end

    always @(posedge clk) begin
        prod_q <= from_dl(bus.mac_a) * from_dl(bus.mac_b);
        pnan_q <= (bus.mac_a == 16'hFFFF) || (bus.mac_b == 16'hFFFF);
        acc_q  <= bus.mac_clr ? 0.0 : acc_q + prod_q;
        anan_q <= bus.mac_clr ? 1'b0 : (anan_q | pnan_q);
    end

    always_comb begin
        acc_dl = to_dl(acc_q);
    end

    assign bus.mac_acc = anan_q ? 16'hFFFF : acc_dl;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          len;
        logic [15:0] a [3];
        logic [15:0] b [3];
        bit          gap;
        int          hold;
        logic [15:0] exp_data;
        logic        exp_nan;
    } vec_t;

    vec_t vecs [6];

    // Runs one job end to end: request, stream pairs, wait, check, consume.
    task automatic run_job(input vec_t v);
        int s_edge;
        int last_acc;
        int k;
        int n;
        int rc;
        bit phase;
        bit drv;
        bit rdy;

        @(negedge clk);
        chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
        bus.start   = 1'b1;
        bus.cfg_len = CNT_W'(v.len);
        @(negedge clk);
        bus.start   = 1'b0;
        s_edge      = cyc;
        chk("mac_clr_in_clr", 32'(bus.mac_clr), 32'd1);
        chk("busy_in_clr", 32'(bus.busy), 32'd1);

        k        = 0;
        n        = 0;
        phase    = 1'b0;
        last_acc = s_edge;
        while (k < v.len && n < 100) begin
            drv = !(v.gap && phase);
            bus.in_valid = drv;
            bus.in_a     = drv ? v.a[k] : 16'h0;
            bus.in_b     = drv ? v.b[k] : 16'h0;
            rdy          = bus.in_ready;
            @(negedge clk);
            n++;
            phase = ~phase;
            if (rdy && drv) begin
                k++;
                last_acc = cyc;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_a     = 16'h0;
        bus.in_b     = 16'h0;
        chk("pairs_accepted", 32'(k), 32'(v.len));

        n  = 0;
        rc = 0;
        while (!bus.res_valid && n < 50) begin
            if (bus.in_ready) rc++;
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", 32'(bus.res_valid), 32'd1);
        if (v.len == 0) begin
            chk("len0_latency", 32'(cyc - s_edge), 32'(MAC_LAT + 2));
            chk("len0_no_in_ready", 32'(rc), 32'd0);
        end else begin
            chk("drain_latency", 32'(cyc - last_acc), 32'(MAC_LAT + 1));
        end
        chk("res_data", 32'(bus.res_data), 32'(v.exp_data));
        chk("res_nan", 32'(bus.res_nan), 32'(v.exp_nan));

        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_data", 32'(bus.res_data), 32'(v.exp_data));
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end

        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("idle_after_job", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        vec_t ab;
        int   n;
        int   seen;

        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;

        // len, a[], b[], gap, hold, exp_data, exp_nan
        vecs[0] = '{2, '{16'h3E00, 16'h3E00, 16'h0}, '{16'h4000, 16'h4000, 16'h0}, 1'b0, 0, 16'h4200, 1'b0};
        vecs[1] = '{2, '{16'h3E00, 16'h3E00, 16'h0}, '{16'h4000, 16'h4000, 16'h0}, 1'b1, 5, 16'h4200, 1'b0};
        vecs[2] = '{0, '{16'h0, 16'h0, 16'h0},       '{16'h0, 16'h0, 16'h0},       1'b0, 0, 16'h0000, 1'b0};
        vecs[3] = '{3, '{16'h3E00, 16'hFFFF, 16'h3E00}, '{16'h4000, 16'h3E00, 16'h4000}, 1'b0, 0, 16'hFFFF, 1'b1};
        vecs[4] = '{3, '{16'h3E00, 16'h4000, 16'hBE00}, '{16'h3E00, 16'h4000, 16'h3E00}, 1'b0, 0, 16'h4200, 1'b0};
        vecs[5] = '{1, '{16'h4000, 16'h0, 16'h0},    '{16'h4200, 16'h0, 16'h0},    1'b1, 2, 16'h4400, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.res_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_mac_a", 32'(bus.mac_a), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
        end

        // Abort after the first of three pairs, then a fresh len=1 job.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.cfg_len = 8'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        @(negedge clk);
        chk("abort_in_run", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4000;
        bus.in_b     = 16'h4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_mac_a", 32'(bus.mac_a), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        ab = '{1, '{16'h3E00, 16'h0, 16'h0}, '{16'h3E00, 16'h0, 16'h0}, 1'b0, 0, 16'h3E00, 1'b0};
        run_job(ab);

        // Reset during DRAIN.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.cfg_len = 8'd1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4000;
        bus.in_b     = 16'h4000;
        n = 0;
        while (!bus.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_res_data", 32'(bus.res_data), 32'd0);
        chk("mid_rst_res_nan", 32'(bus.res_nan), 32'd0);
        chk("mid_rst_mac", 32'({bus.mac_a, bus.mac_b}), 32'd0);
        chk("mid_rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dlfloat_dot_ctrl.md
# dlfloat_dot_ctrl

Sequencer that runs length-N DLFloat16 dot products on the shared multiply-accumulate datapath. It accepts a job length, streams operand pairs into the MAC with a valid/ready handshake, and clears the accumulator before each job. After the last product has drained through the MAC pipeline it presents the accumulated 16-bit result on a held valid/ready output. It sits between the host-side operand unpacker and the MAC.

## Interface
- MAC_LAT, 2: edge count from an operand pair on mac_a/mac_b to the accumulator holding its contribution (multiplier register plus accumulator register).
- CNT_W, 8: width of the job-length and pair counters.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  job request, sampled only in IDLE
- cfg_len  in  CNT_W  number of operand pairs in the job, captured with start
- start_ready  out  1  high only in IDLE
- abort  in  1  synchronous job cancel
- in_valid  in  1  operand pair valid
- in_a, in_b  in  16  DLFloat16 operands (1 sign, 6 exponent with bias 31, 9 mantissa)
- in_ready  out  1  high only in RUN
- mac_a, mac_b  out  16  registered operands to the MAC; 0 whenever no pair is issued
- mac_clr  out  1  synchronous accumulator clear, one cycle per job
- mac_acc  in  16  accumulator value from the MAC
- res_data  out  16  captured dot-product result
- res_nan  out  1  set if any accepted operand or the captured result equals 16'hFFFF
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE: start_ready=1 and mac_a=mac_b=0. When start=1, the block captures cfg_len into len_q, clears pair_cnt and the NaN flag, and moves to CLR.
- CLR: mac_clr=1 for exactly one cycle. Next state is RUN if len_q≠0; otherwise DRAIN with dcnt=MAC_LAT.
- RUN: in_ready=1.
  - On in_valid: mac_a<=in_a, mac_b<=in_b, pair_cnt++, and the NaN flag is set if either operand equals 16'hFFFF.
  - Without in_valid: mac_a<=0, mac_b<=0. A zero-operand bubble contributes nothing.
  - On acceptance with pair_cnt==len_q-1: move to DRAIN with dcnt<=MAC_LAT.
- DRAIN: mac_a=mac_b=0 and in_ready=0.
  - While dcnt≠0: dcnt--.
  - On the edge where dcnt==0: res_data<=mac_acc, res_nan<=flag | (mac_acc==16'hFFFF), and move to DONE.
- DONE: res_valid=1, with res_data and res_nan held stable until the handshake. When res_ready=1, res_valid drops on the next edge and the state returns to IDLE.
- abort=1 in any state other than IDLE: next state is IDLE, mac_a=mac_b=0, res_valid=0, and no result is produced. abort has priority over all other inputs. abort in IDLE has no effect.
- start while busy is ignored (start_ready=0).
- pair_cnt never wraps within a job, because len_q ≤ 2^CNT_W−1.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, mac_a=mac_b=0, mac_clr=0
  - res_data=0, res_nan=0, res_valid=0, busy=0
  - counters=0
  - This holds mid-job too; no partial result is ever flagged valid.
- All outputs are registered except start_ready, in_ready and busy, which are decoded from state.
- Handshakes follow valid/ready semantics: a transfer happens on an edge with both high. in_valid may be held across bubbles.
- Latency with no back-pressure:
  - start edge S, CLR at S+1, first acceptance at S+2 at the earliest.
  - If the last pair is accepted at edge E, DRAIN spans E+1..E+MAC_LAT+1, result is captured at E+MAC_LAT+1, and res_valid=1 from that edge.
  - len_q=0: capture at S+MAC_LAT+2. res_data equals the cleared accumulator (0x0000).
- Back-to-back jobs: a new start is accepted at the edge after the res handshake, so there is at least 1 idle cycle between jobs.
- mac_clr is never asserted while a nonzero pair is in flight.

## Test plan
- len=2, pairs (0x3E00,0x4000),(0x3E00,0x4000), in_valid held high: res_data=0x4200 (1·2+1·2=4.0), res_nan=0, res_valid exactly MAC_LAT+1 edges after the 2nd acceptance.
- Same job with one-cycle in_valid gaps between pairs and res_ready held low for 5 cycles: res_data=0x4200, held stable with res_valid=1 until res_ready; busy=1 throughout.
- len=0: no in_ready cycle, res_data=0x0000, res_valid at S+4 (MAC_LAT=2).
- len=3 with second pair in_a=0xFFFF: res_nan=1, res_data=0xFFFF.
- abort asserted during RUN after 1 of 3 pairs, then a new len=1 job (0x3E00,0x3E00): no res_valid for the aborted job; new job returns 0x3E00 (the accumulator was cleared).
- rst_n low for 1 cycle during DRAIN: every output returns to its reset value on the next edge, no res_valid follows, and start_ready=1.
